// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: base op codes, multiply/divide op codes,
// FSM state encoding, shifter type codes and the signedness helpers for the MD unit.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_PASS = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'hA;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [1:0] SH_SRL = 2'd0;
  localparam logic [1:0] SH_SRA = 2'd1;
  localparam logic [1:0] SH_SLL = 2'd2;

  typedef struct packed {
    logic cf;
    logic zf;
    logic vf;
    logic sf;
  } alu_flags_t;

  function automatic logic md_signed_a(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_signed_b(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative multiply/divide datapath: works on operand magnitudes, one shift-add or
// restoring-subtract step per cycle, then a registered sign/selection fix.
module md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic             step,
  input  logic             fix,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic             fix_done,
  output logic [WIDTH-1:0] res
);

  logic [2:0]       op_q;
  logic             neg_a, neg_b, b_zero;
  logic [WIDTH-1:0] hi, lo, mb;
  logic [SHW-1:0]   cnt;

  logic             neg_a_c, neg_b_c;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, fixed;

  assign neg_a_c = md_signed_a(md_op) && a[WIDTH-1];
  assign neg_b_c = md_signed_b(md_op) && b[WIDTH-1];
  assign last    = (cnt == SHW'(WIDTH - 1));

  // hi:lo is the product accumulator when multiplying, remainder:quotient when dividing
  assign addend    = lo[0] ? mb : '0;
  assign mul_sum   = {1'b0, hi} + {1'b0, addend};
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mb};

  // Most-negative / -1 needs no special case: its magnitude path already yields a and 0
  always_comb begin
    prod_s = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
    quo_s  = (neg_a ^ neg_b) ? -lo : lo;
    rem_s  = neg_a ? -hi : hi;
    fixed  = '0;
    case (op_q)
      MD_MUL:                       fixed = prod_s[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fixed = prod_s[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              fixed = b_zero ? '1 : quo_s;
      default:                      fixed = rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      b_zero   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mb       <= '0;
      cnt      <= '0;
      res      <= '0;
      fix_done <= 1'b0;
    end else if (flush) begin
      cnt      <= '0;
      fix_done <= 1'b0;
    end else if (start) begin
      op_q     <= md_op;
      neg_a    <= neg_a_c;
      neg_b    <= neg_b_c;
      b_zero   <= (b == '0);
      hi       <= '0;
      lo       <= neg_a_c ? -a : a;
      mb       <= neg_b_c ? -b : b;
      cnt      <= '0;
      fix_done <= 1'b0;
    end else if (step) begin
      cnt <= cnt + SHW'(1);
      if (op_q[2]) begin
        if (!div_diff[WIDTH]) begin
          hi <= div_diff[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= div_shift[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end else if (fix) begin
      // First FIX cycle registers the corrected result, second hands it to the top
      if (!fix_done) begin
        res      <= fixed;
        fix_done <= 1'b1;
      end else begin
        fix_done <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_md_alu.sv
// Registered EX-stage ALU: single-cycle base ops plus an iterative RV32M-style
// multiply/divide unit behind a valid/ready handshake with pipeline flush.
module seq_md_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_md,
  input  logic [3:0]       alufn,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cf,
  output logic             zf,
  output logic             vf,
  output logic             sf,
  output logic             busy
);

  logic [1:0]       state;
  logic             accept;
  logic             md_last, md_fix_done;
  logic [WIDTH-1:0] md_res;

  logic             sub_op;
  logic [WIDTH-1:0] op_b, sum, sh_out, alu_r;
  logic [WIDTH:0]   sum_ext;
  logic [SHW-1:0]   shamt;
  logic [1:0]       sh_type;
  alu_flags_t       flg;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign busy     = (state != ST_IDLE);

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (accept && is_md),
    .step     (state == ST_CALC),
    .fix      (state == ST_FIX),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .last     (md_last),
    .fix_done (md_fix_done),
    .res      (md_res)
  );

  // Compares reuse the subtractor so SLT/SLTU come straight from the flags
  assign sub_op  = (alufn == ALU_SUB) || (alufn == ALU_SLT) || (alufn == ALU_SLTU);
  assign op_b    = sub_op ? ~b : b;
  assign sum_ext = {1'b0, a} + {1'b0, op_b} + {{WIDTH{1'b0}}, sub_op};
  assign sum     = sum_ext[WIDTH-1:0];
  assign flg.cf  = sum_ext[WIDTH];
  assign flg.zf  = (sum == '0);
  assign flg.sf  = sum[WIDTH-1];
  assign flg.vf  = a[WIDTH-1] ^ op_b[WIDTH-1] ^ sum[WIDTH-1] ^ sum_ext[WIDTH];

  assign shamt = b[SHW-1:0];

  always_comb begin
    sh_type = SH_SRL;
    if (alufn == ALU_SRA) sh_type = SH_SRA;
    else if (alufn == ALU_SLL) sh_type = SH_SLL;
  end

  always_comb begin
    sh_out = '0;
    case (sh_type)
      SH_SLL:  sh_out = a << shamt;
      SH_SRA:  sh_out = $unsigned($signed(a) >>> shamt);
      default: sh_out = a >> shamt;
    endcase
  end

  always_comb begin
    alu_r = '0;
    case (alufn)
      ALU_ADD, ALU_SUB:          alu_r = sum;
      ALU_PASS:                  alu_r = b;
      ALU_OR:                    alu_r = a | b;
      ALU_AND:                   alu_r = a & b;
      ALU_XOR:                   alu_r = a ^ b;
      ALU_SRL, ALU_SRA, ALU_SLL: alu_r = sh_out;
      ALU_SLT:                   alu_r[0] = (flg.sf != flg.vf);
      ALU_SLTU:                  alu_r[0] = ~flg.cf;
      default:                   alu_r = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      r         <= '0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      vf        <= 1'b0;
      sf        <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_md) begin
              state     <= ST_CALC;
              out_valid <= 1'b0;
            end else begin
              r         <= alu_r;
              cf        <= flg.cf;
              zf        <= flg.zf;
              vf        <= flg.vf;
              sf        <= flg.sf;
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_CALC: begin
          if (md_last) state <= ST_FIX;
        end
        ST_FIX: begin
          if (md_fix_done) begin
            state     <= ST_IDLE;
            r         <= md_res;
            cf        <= 1'b0;
            zf        <= 1'b0;
            vf        <= 1'b0;
            sf        <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
